// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Decides, every cycle, whether the pipeline runs, stalls for a load-use
// dependency, flushes behind a taken branch/jump, or freezes while data
// memory is busy. Controls are combinational (zero latency); state_o is the
// condition that was in force during the previous cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_id_ir, id_ex_ir,        instruction registers of IF/ID, ID/EX, EX/MEM
//   ex_mem_ir                  (32'h0 is a bubble)
//   mem_cond                   branch condition latched with ex_mem_ir
//   mem_busy                   data memory not ready, hold the pipeline
//   pc_write, if_id_write      1 = register advances
//   if_id_flush, id_ex_flush,  1 = register loads 32'h0 on the next edge
//   ex_mem_flush
//   state_o                    previous-cycle condition: RUN/STALL/FLUSH/FREEZE
//   stall_cnt, flush_cnt,      event counters
//   freeze_cnt
//
// Build option: define HAZARD_PERF_CNT_EN to build saturating event counters;
// without it the counter ports are tied to zero and no counter flops exist.
//
// Handshake: none. mem_busy is a level-sensitive hold request; while it is
// high no register advances and no register is flushed.

module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_id_ir,
    input  logic [31:0] id_ex_ir,
    input  logic [31:0] ex_mem_ir,
    input  logic [31:0] mem_cond,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] freeze_cnt
);

    // Opcode map shared with the decoder (DLX encoding).
    localparam logic [5:0] OP_OPERATION = 6'h00;
    localparam logic [5:0] OP_J         = 6'h02;
    localparam logic [5:0] OP_BEQZ      = 6'h04;
    localparam logic [5:0] OP_BNEZ      = 6'h05;
    localparam logic [5:0] OP_LW        = 6'h23;
    localparam logic [5:0] OP_SW        = 6'h2B;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FREEZE = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   pending_q, pending_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0] if_op, id_op, mem_op;
    logic [4:0] if_rs1, if_rs2, id_lw_rd;
    logic       if_reads_rs1, if_reads_rs2;
    logic       load_use, taken;

    assign if_op    = if_id_ir[31:26];
    assign if_rs1   = if_id_ir[25:21];
    assign if_rs2   = if_id_ir[20:16];
    assign id_op    = id_ex_ir[31:26];
    assign id_lw_rd = id_ex_ir[20:16];
    assign mem_op   = ex_mem_ir[31:26];

    always_comb begin
        if_reads_rs1 = 1'b0;
        if_reads_rs2 = 1'b0;
        case (if_op)
            OP_OPERATION, OP_SW: begin
                if_reads_rs1 = 1'b1;
                if_reads_rs2 = 1'b1;
            end
            OP_LW, OP_BEQZ, OP_BNEZ: if_reads_rs1 = 1'b1;
            default: ;
        endcase
    end

    // A bubble decodes as an OPERATION on r0; the rd != 0 term keeps it
    // from ever matching. After a FLUSH, IF/ID holds a bubble, so any
    // apparent dependency in that cycle is stale and ignored.
    always_comb begin
        load_use = 1'b0;
        if ((id_op == OP_LW) && (id_lw_rd != 5'd0) && (state_q != ST_FLUSH)) begin
            load_use = (if_reads_rs1 && (if_rs1 == id_lw_rd)) ||
                       (if_reads_rs2 && (if_rs2 == id_lw_rd));
        end
    end

    // pending_q remembers a branch resolved while the pipeline was frozen,
    // since ex_mem_ir/mem_cond may no longer be valid once memory releases.
    assign taken = (((mem_op == OP_BEQZ) || (mem_op == OP_BNEZ) || (mem_op == OP_J)) &&
                    (mem_cond != 32'h0)) || pending_q;

    // ------------------------------------------------------------------
    // Condition select, FREEZE > FLUSH > STALL > RUN
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ST_RUN;
        if (!rst_n)        state_d = ST_RUN;
        else if (mem_busy) state_d = ST_FREEZE;
        else if (taken)    state_d = ST_FLUSH;
        else if (load_use) state_d = ST_STALL;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        case (state_d)
            ST_FREEZE: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end
            ST_STALL: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        if (state_d == ST_FREEZE)     pending_d = taken;
        else if (state_d == ST_FLUSH) pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign state_o = state_q;

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
    logic [15:0] stall_cnt_d, flush_cnt_d, freeze_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if ((state_d == ST_STALL) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if ((state_d == ST_FLUSH) && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
        if ((state_d == ST_FREEZE) && (freeze_cnt_q != 16'hFFFF))
            freeze_cnt_d = freeze_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= 16'h0;
            flush_cnt_q  <= 16'h0;
            freeze_cnt_q <= 16'h0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`else
    assign stall_cnt  = 16'h0;
    assign flush_cnt  = 16'h0;
    assign freeze_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Inputs are driven 1 time unit after the
// rising edge, outputs are sampled 1 unit later, well before the next edge.

module tb_hazard_ctrl;

    localparam logic [5:0] OPC_OPER = 6'h00;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_BEQZ = 6'h04;
    localparam logic [5:0] OPC_BNEZ = 6'h05;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;

    localparam logic [1:0] C_RUN    = 2'd0;
    localparam logic [1:0] C_STALL  = 2'd1;
    localparam logic [1:0] C_FLUSH  = 2'd2;
    localparam logic [1:0] C_FREEZE = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_id_ir, id_ex_ir, ex_mem_ir, mem_cond;
    logic        mem_busy;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

    int total = 0;
    int bad   = 0;
    int e_stall = 0, e_flush = 0, e_freeze = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_id_ir     (if_id_ir),
        .id_ex_ir     (id_ex_ir),
        .ex_mem_ir    (ex_mem_ir),
        .mem_cond     (mem_cond),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .state_o      (state_o),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .freeze_cnt   (freeze_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] i_oper(input int rs1, input int rs2, input int rd);
        return {OPC_OPER, 5'(rs1), 5'(rs2), 5'(rd), 11'h020};
    endfunction
    function automatic logic [31:0] i_lw(input int rd, input int rs1);
        return {OPC_LW, 5'(rs1), 5'(rd), 16'h0000};
    endfunction
    function automatic logic [31:0] i_sw(input int rs1, input int rs2);
        return {OPC_SW, 5'(rs1), 5'(rs2), 16'h0004};
    endfunction
    function automatic logic [31:0] i_br(input logic [5:0] opc, input int rs1);
        return {opc, 5'(rs1), 5'd0, 16'h0010};
    endfunction

    // Control vector {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
    function automatic logic [4:0] ctl_of(input logic [1:0] c);
        case (c)
            C_STALL:  return 5'b00010;
            C_FLUSH:  return 5'b11111;
            C_FREEZE: return 5'b00000;
            default:  return 5'b11000;
        endcase
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return (v > 65535) ? 65535 : v;
`else
        return 0 * v;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".stall_cnt"},  {16'h0, stall_cnt},  32'(exp_cnt(e_stall)));
        check({tag, ".flush_cnt"},  {16'h0, flush_cnt},  32'(exp_cnt(e_flush)));
        check({tag, ".freeze_cnt"}, {16'h0, freeze_cnt}, 32'(exp_cnt(e_freeze)));
    endtask

    // Check this cycle's controls and previous-cycle state, then advance a clock.
    task automatic step(input string tag, input logic [1:0] exp_cond, input logic [1:0] exp_prev);
        #1;
        check({tag, ".ctl"}, {27'h0, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush},
              {27'h0, ctl_of(exp_cond)});
        check({tag, ".state"}, {30'h0, state_o}, {30'h0, exp_prev});
        @(posedge clk);
        #1;
        case (exp_cond)
            C_STALL:  e_stall++;
            C_FLUSH:  e_flush++;
            C_FREEZE: e_freeze++;
            default: ;
        endcase
    endtask

    task automatic idle_inputs();
        if_id_ir  = 32'h0;
        id_ex_ir  = 32'h0;
        ex_mem_ir = 32'h0;
        mem_cond  = 32'h0;
        mem_busy  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst.ctl", {27'h0, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush},
              32'h18);
        check("rst.state", {30'h0, state_o}, 32'h0);
        check_cnts("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use through rs1: one stall, then bubble in ID/EX gives RUN
        id_ex_ir = i_lw(2, 1);
        if_id_ir = i_oper(2, 4, 3);
        step("lu_rs1", C_STALL, C_RUN);
        id_ex_ir = 32'h0;
        step("lu_rs1_after", C_RUN, C_STALL);
        check_cnts("lu_rs1");

        // Load-use through rs2 of a store
        id_ex_ir = i_lw(5, 1);
        if_id_ir = i_sw(1, 5);
        step("lu_sw_rs2", C_STALL, C_RUN);
        // Jump reads no register
        if_id_ir = i_br(OPC_J, 5);
        step("lu_j", C_RUN, C_STALL);
        // BNEZ reads rs1
        if_id_ir = i_br(OPC_BNEZ, 5);
        step("lu_bnez", C_STALL, C_RUN);
        // LW to r0 never stalls
        id_ex_ir = i_lw(0, 1);
        if_id_ir = i_oper(0, 4, 3);
        step("lu_r0", C_RUN, C_STALL);

        // Taken branch with load-use in same cycle: FLUSH only
        ex_mem_ir = i_br(OPC_BEQZ, 7);
        mem_cond  = 32'h1;
        id_ex_ir  = i_lw(2, 1);
        if_id_ir  = i_oper(2, 4, 3);
        step("br_lu", C_FLUSH, C_RUN);
        ex_mem_ir = 32'h0;
        mem_cond  = 32'h0;
        step("after_flush", C_RUN, C_FLUSH);
        check_cnts("br_lu");
        idle_inputs();

        // Untaken and taken jump
        ex_mem_ir = i_br(OPC_BEQZ, 7);
        step("beqz_nt", C_RUN, C_RUN);
        ex_mem_ir = i_br(OPC_J, 0);
        mem_cond  = 32'h8000_0000;
        step("j_t", C_FLUSH, C_RUN);
        idle_inputs();
        step("j_after", C_RUN, C_FLUSH);

        // Branch resolved under freeze, flushed on release from pending
        ex_mem_ir = i_br(OPC_BNEZ, 7);
        mem_cond  = 32'h1;
        mem_busy  = 1'b1;
        step("frz1", C_FREEZE, C_RUN);
        mem_cond  = 32'h0;
        step("frz2", C_FREEZE, C_FREEZE);
        step("frz3", C_FREEZE, C_FREEZE);
        mem_busy  = 1'b0;
        ex_mem_ir = 32'h0;
        step("frz_rel", C_FLUSH, C_FREEZE);
        step("frz_done", C_RUN, C_FLUSH);
        check_cnts("frz");

        // Freeze during stall, hazard re-evaluated after release
        id_ex_ir = i_lw(6, 2);
        if_id_ir = i_oper(1, 6, 9);
        step("sf_stall", C_STALL, C_RUN);
        mem_busy = 1'b1;
        step("sf_freeze", C_FREEZE, C_STALL);
        mem_busy = 1'b0;
        step("sf_restall", C_STALL, C_FREEZE);
        idle_inputs();
        step("sf_run", C_RUN, C_STALL);
        check_cnts("sf");

        // Reset in the middle of a freeze with a pending branch
        ex_mem_ir = i_br(OPC_BNEZ, 3);
        mem_cond  = 32'h1;
        mem_busy  = 1'b1;
        step("rf_freeze", C_FREEZE, C_RUN);
        ex_mem_ir = 32'h0;
        mem_cond  = 32'h0;
        rst_n = 1'b0;
        #1;
        check("rf.ctl", {27'h0, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush},
              32'h18);
        check("rf.state", {30'h0, state_o}, 32'h0);
        e_stall = 0; e_flush = 0; e_freeze = 0;
        check_cnts("rf");
        mem_busy = 1'b0;
        rst_n = 1'b1;
        step("rf_post", C_RUN, C_RUN);
        step("rf_post2", C_RUN, C_RUN);

        // Long run of back-to-back stalls (saturates counter when built)
        id_ex_ir = i_lw(4, 1);
        if_id_ir = i_oper(4, 4, 8);
        step("long_first", C_STALL, C_RUN);
        for (int i = 0; i < 65539; i++) @(posedge clk);
        e_stall += 65539;
        #1;
        check("long.ctl", {27'h0, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush},
              32'h02);
        check("long.state", {30'h0, state_o}, 32'h1);
        check_cnts("long");
        idle_inputs();
        step("long_end", C_RUN, C_STALL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
